// File: rtl/mmio_led_pkg.sv
// Shared definitions for the memory-mapped LED peripheral: mode encodings,
// CFG field positions and register word offsets within the address window.
package mmio_led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_PWM    = 2'b10,
        MODE_RSVD   = 2'b11
    } led_mode_t;

    localparam int MODE_LSB   = 0;
    localparam int MODE_W     = 2;
    localparam int DUTY_LSB   = 8;
    localparam int HALF_LSB   = 16;

    localparam int OUT_OFFSET = 0;
    localparam int CFG_OFFSET = 1;

endpackage

// File: rtl/led_channel.sv
// One LED channel: owns its blink counter and phase, and selects the next
// LED level from static, blink or PWM according to its CFG word.
module led_channel
    import mmio_led_pkg::*;
#(
    parameter int PWM_W   = 8,
    parameter int BLINK_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clk_enable,
    input  logic [31:0]      i_cfg,
    input  logic             i_static,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    input  logic             i_restart,
    output logic             o_led_next
);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;

    led_mode_t          w_mode;
    logic [PWM_W-1:0]   w_duty;
    logic [BLINK_W-1:0] w_half;
    logic               w_unused_cfg;

    assign w_mode       = led_mode_t'(i_cfg[MODE_LSB +: MODE_W]);
    assign w_duty       = i_cfg[DUTY_LSB +: PWM_W];
    assign w_half       = i_cfg[HALF_LSB +: BLINK_W];
    // Bits between the mode and duty fields carry no meaning here.
    assign w_unused_cfg = ^i_cfg;

    // Blink timebase: a config write restarts from phase 0, otherwise count
    // enables up to the half-period and toggle the phase on reaching it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (i_restart) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (i_clk_enable) begin
            if (r_blink_cnt == w_half) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Level selection; the reserved mode behaves as static.
    always_comb begin
        o_led_next = i_static;
        case (w_mode)
            MODE_BLINK: o_led_next = r_phase;
            MODE_PWM:   o_led_next = (i_pwm_cnt < w_duty);
            default:    o_led_next = i_static;
        endcase
    end

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED peripheral: OUT and CFG[i] registers in a NUM_LEDS+1 word
// window at BASE_ADDR, a shared PWM counter, per-channel blink/PWM/static
// selection and a registered readback path with a hit flag.
// Optional build macro MMIO_LED_ACTIVE_LOW_EN inverts the led port for
// active-low boards; readback always returns the logical register values.
module mmio_led_ctrl
    import mmio_led_pkg::*;
#(
    parameter int                NUM_LEDS  = 5,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0,
    parameter int                PWM_W     = 8,
    parameter int                BLINK_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_enable,
    input  logic [ADDR_W-1:0]   write_address,
    input  logic [31:0]         write_data,
    input  logic                write_enable,
    input  logic [ADDR_W-1:0]   read_address,
    output logic [31:0]         read_data,
    output logic                hit,
    output logic [NUM_LEDS-1:0] led
);

    localparam logic [ADDR_W-1:0] WIN_WORDS = ADDR_W'(NUM_LEDS + 1);
    localparam logic [ADDR_W-1:0] OUT_ADDR  = ADDR_W'(OUT_OFFSET);

    logic [NUM_LEDS-1:0] r_out;
    logic [31:0]         r_cfg [NUM_LEDS];
    logic [PWM_W-1:0]    r_pwm_cnt;
    logic [NUM_LEDS-1:0] r_led;
    logic [31:0]         r_read_data;
    logic                r_hit;

    logic [ADDR_W-1:0]   w_wr_off;
    logic [ADDR_W-1:0]   w_rd_off;
    logic                w_wr_in;
    logic                w_rd_in;
    logic                w_wr_fire;
    logic [NUM_LEDS-1:0] w_restart;
    logic [NUM_LEDS-1:0] w_led_next;
    logic [31:0]         w_rd_word;

    assign w_wr_off  = write_address - BASE_ADDR;
    assign w_rd_off  = read_address - BASE_ADDR;
    assign w_wr_in   = (write_address >= BASE_ADDR) && (w_wr_off < WIN_WORDS);
    assign w_rd_in   = (read_address >= BASE_ADDR) && (w_rd_off < WIN_WORDS);
    assign w_wr_fire = write_enable && clk_enable && w_wr_in;

    // Register file: OUT keeps only the implemented channel bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_cfg[i] <= '0;
            end
        end else if (w_wr_fire) begin
            if (w_wr_off == OUT_ADDR) begin
                r_out <= write_data[NUM_LEDS-1:0];
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_wr_off == ADDR_W'(CFG_OFFSET + i)) begin
                    r_cfg[i] <= write_data;
                end
            end
        end
    end

    // Shared PWM timebase, wraps naturally at 2**PWM_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else if (clk_enable) begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        assign w_restart[g] = w_wr_fire && (w_wr_off == ADDR_W'(CFG_OFFSET + g));

        led_channel #(
            .PWM_W   (PWM_W),
            .BLINK_W (BLINK_W)
        ) u_channel (
            .i_clk        (clk),
            .i_reset      (reset),
            .i_clk_enable (clk_enable),
            .i_cfg        (r_cfg[g]),
            .i_static     (r_out[g]),
            .i_pwm_cnt    (r_pwm_cnt),
            .i_restart    (w_restart[g]),
            .o_led_next   (w_led_next[g])
        );
    end

    // LED drive register, advancing only on enable cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= '0;
        end else if (clk_enable) begin
            r_led <= w_led_next;
        end
    end

    // Readback mux over the current (pre-edge) register contents.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_off == OUT_ADDR) begin
            w_rd_word = 32'(r_out);
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_rd_off == ADDR_W'(CFG_OFFSET + i)) begin
                w_rd_word = r_cfg[i];
            end
        end
    end

    // Registered readback, one enable of latency like the data memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= '0;
            r_hit       <= 1'b0;
        end else if (clk_enable) begin
            r_hit       <= w_rd_in;
            r_read_data <= w_rd_in ? w_rd_word : 32'h0;
        end
    end

    assign read_data = r_read_data;
    assign hit       = r_hit;

`ifdef MMIO_LED_ACTIVE_LOW_EN
    assign led = ~r_led;
`else
    assign led = r_led;
`endif

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Self-checking bench for mmio_led_ctrl with a shadow register model and a
// scoreboard queue of expected readback / LED values.
module tb_mmio_led_ctrl;

    localparam int         N    = 5;
    localparam logic [7:0] BASE = 8'hF0;
`ifdef MMIO_LED_ACTIVE_LOW_EN
    localparam bit ACT_LOW = 1'b1;
`else
    localparam bit ACT_LOW = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_enable;
    logic [7:0]   write_address;
    logic [31:0]  write_data;
    logic         write_enable;
    logic [7:0]   read_address;
    logic [31:0]  read_data;
    logic         hit;
    logic [N-1:0] led;

    typedef struct {
        logic        hit;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic        led_q[$];
    logic [4:0]  sh_out;
    logic [31:0] sh_cfg[N];
    int          total = 0;
    int          bad   = 0;

    mmio_led_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .read_address  (read_address),
        .read_data     (read_data),
        .hit           (hit),
        .led           (led)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] pin(input logic [4:0] lvl);
        return ACT_LOW ? ~lvl : lvl;
    endfunction

    function automatic bit in_win(input logic [7:0] a);
        int off;
        off = int'(a) - int'(BASE);
        return (off >= 0) && (off <= N);
    endfunction

    function automatic logic [31:0] sh_word(input logic [7:0] a);
        int off;
        off = int'(a) - int'(BASE);
        if (off == 0) return {27'b0, sh_out};
        return sh_cfg[off-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_shadow();
        sh_out = '0;
        for (int i = 0; i < N; i++) sh_cfg[i] = '0;
    endtask

    // One bus cycle; with chk set the expected readback (old contents) is
    // queued at drive time and compared once the DUT has registered it.
    task automatic bus(input logic en, input logic we, input logic [7:0] wa,
                       input logic [31:0] wd, input logic [7:0] ra,
                       input bit chk, input string tag);
        rd_exp_t e;
        int      off;
        if (chk) begin
            e.hit  = in_win(ra);
            e.data = e.hit ? sh_word(ra) : 32'h0;
            rd_q.push_back(e);
        end
        clk_enable    = en;
        write_enable  = we;
        write_address = wa;
        write_data    = wd;
        read_address  = ra;
        tick();
        if (en && we && in_win(wa)) begin
            off = int'(wa) - int'(BASE);
            if (off == 0) sh_out = wd[4:0];
            else          sh_cfg[off-1] = wd;
        end
        if (chk) begin
            e = rd_q.pop_front();
            check({tag, "_hit"}, {31'b0, hit}, {31'b0, e.hit});
            check({tag, "_data"}, read_data, e.data);
        end
        write_enable = 1'b0;
        clk_enable   = 1'b0;
    endtask

    // Blink steps: k counts enables since the last config write; the LED
    // shows the phase from before each enable, so it holds 4 enables per level.
    task automatic blink_steps(input int n, input string tag);
        logic e;
        for (int k = 1; k <= n; k++) begin
            led_q.push_back(logic'(((k - 1) / 4) % 2));
            clk_enable = 1'b1;
            tick();
            e = led_q.pop_front();
            check({tag, "_en"}, {31'b0, led[1] ^ ACT_LOW}, {31'b0, e});
            clk_enable = 1'b0;
            tick();
            check({tag, "_hold"}, {31'b0, led[1] ^ ACT_LOW}, {31'b0, e});
        end
    endtask

    task automatic pwm_count(input int cycles, output int cnt);
        cnt = 0;
        clk_enable = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            tick();
            cnt += int'(led[2] ^ ACT_LOW);
        end
        clk_enable = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b1; clk_enable = 1'b0; write_enable = 1'b0;
        write_address = '0; write_data = '0; read_address = '0;
        clear_shadow();

        // Reset
        tick(); tick();
        check("rst_led", {27'b0, led}, {27'b0, pin(5'h00)});
        check("rst_rdata", read_data, 32'h0);
        check("rst_hit", {31'b0, hit}, 32'h0);
        reset = 1'b0;
        bus(1, 0, 8'h00, 32'h0, BASE + 8'd1, 1, "rst_cfg0");

        // Static mode
        bus(1, 1, BASE, 32'h15, 8'h00, 0, "");
        check("static_write_edge", {27'b0, led}, {27'b0, pin(5'h00)});
        bus(1, 0, 8'h00, 32'h0, 8'h00, 0, "");
        check("static_led", {27'b0, led}, {27'b0, pin(5'h15)});
        bus(0, 1, BASE, 32'h0A, 8'h00, 0, "");
        bus(1, 0, 8'h00, 32'h0, 8'h00, 0, "");
        check("static_no_en_write", {27'b0, led}, {27'b0, pin(5'h15)});
        bus(1, 0, 8'h00, 32'h0, BASE, 1, "rd_out");
        bus(1, 1, BASE, 32'hFFFF_FFF5, 8'h00, 0, "");
        bus(1, 0, 8'h00, 32'h0, BASE, 1, "rd_out_mask");

        // PWM on channel 2
        bus(1, 1, BASE + 8'd3, 32'h0000_4002, 8'h00, 0, "");
        pwm_count(4, cnt);
        for (int p = 0; p < 3; p++) begin
            pwm_count(256, cnt);
            check("pwm_duty64", cnt, 64);
        end
        bus(1, 1, BASE + 8'd3, 32'h0000_0002, 8'h00, 0, "");
        pwm_count(2, cnt);
        pwm_count(256, cnt);
        check("pwm_duty0", cnt, 0);
        bus(1, 1, BASE + 8'd3, 32'h0000_FF02, 8'h00, 0, "");
        pwm_count(2, cnt);
        pwm_count(256, cnt);
        check("pwm_duty255", cnt, 255);
        bus(1, 1, BASE + 8'd3, 32'h0, 8'h00, 0, "");

        // Blink on channel 1, half-period 3, enable every other clock
        bus(1, 1, BASE + 8'd2, 32'h0003_0001, 8'h00, 0, "");
        blink_steps(6, "blink");
        bus(1, 1, BASE + 8'd2, 32'h0003_0001, 8'h00, 0, "");
        check("blink_restart_edge", {31'b0, led[1] ^ ACT_LOW}, 32'h1);
        blink_steps(8, "blink_rst");

        // Address decode and readback
        bus(1, 1, BASE + 8'd1, 32'hA5A5_0301, 8'h00, 0, "");
        bus(1, 0, 8'h00, 32'h0, BASE + 8'd1, 1, "rd_cfg0");
        bus(0, 0, 8'h00, 32'h0, BASE + 8'd6, 0, "");
        check("rd_hold_data", read_data, 32'hA5A5_0301);
        check("rd_hold_hit", {31'b0, hit}, 32'h1);
        bus(1, 0, 8'h00, 32'h0, BASE + 8'd6, 1, "rd_above");
        bus(1, 1, BASE + 8'd6, 32'hFFFF_FFFF, BASE - 8'd1, 1, "rd_below");
        for (int a = 0; a <= N; a++) bus(1, 0, 8'h00, 32'h0, BASE + 8'(a), 1, "rd_win");
        bus(1, 1, BASE + 8'd4, 32'h1234_5678, BASE + 8'd4, 1, "rw_same_old");
        bus(1, 0, 8'h00, 32'h0, BASE + 8'd4, 1, "rw_same_new");

        // Reset during activity
        bus(1, 1, BASE, 32'h1F, 8'h00, 0, "");
        bus(1, 1, BASE + 8'd2, 32'h0000_0001, 8'h00, 0, "");
        bus(1, 1, BASE + 8'd3, 32'h0000_8002, 8'h00, 0, "");
        pwm_count(10, cnt);
        bus(1, 0, 8'h00, 32'h0, BASE, 1, "pre_rst_rd");
        reset = 1'b1;
        clk_enable = 1'b0;
        tick();
        check("midrst_led", {27'b0, led}, {27'b0, pin(5'h00)});
        check("midrst_rdata", read_data, 32'h0);
        check("midrst_hit", {31'b0, hit}, 32'h0);
        reset = 1'b0;
        clear_shadow();
        for (int a = 0; a <= N; a++) bus(1, 0, 8'h00, 32'h0, BASE + 8'(a), 1, "postrst_rd");
        pwm_count(20, cnt);
        check("postrst_led", {27'b0, led}, {27'b0, pin(5'h00)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
